// File: rtl/mem_indirect_sequencer_if.sv
// rtl/mem_indirect_sequencer_if.sv - data-memory strobe/response bundle for the MEM-stage sequencer
interface mem_indirect_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic              memaddr_sel;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_read, mem_write, memaddr_sel,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, memaddr_sel,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_indirect_sequencer.sv
// rtl/mem_indirect_sequencer.sv - LC-3b MEM-stage access sequencer with multi-level LDI/STI indirection
module mem_indirect_sequencer #(
    parameter int DATA_W         = 16,
    parameter int INDIRECT_DEPTH = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [3:0]                    i_opcode,
    input  logic                          i_err_clear,
    mem_indirect_sequencer_if.master      mem,
    output logic                          o_proceed,
    output logic                          o_ptr_load,
    output logic [DATA_W-1:0]             o_ptr_q,
    output logic [2:0]                    o_level,
    output logic                          o_done,
    output logic                          o_timeout_err
);
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam int          TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [2:0]  LAST_LVL  = 3'(INDIRECT_DEPTH - 1);
    localparam logic        TO_EN     = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PTR   = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_ptr_q;
    logic [2:0]          r_level;
    logic [3:0]          r_op_q;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_timeout_err;

    logic w_is_plain_rd, w_is_plain_wr, w_is_ind;
    logic w_timeout, w_accept_ind;
    logic w_read, w_write, w_sel, w_proceed, w_ptr_load, w_done;

    assign w_is_plain_rd = (i_opcode == OP_LDR) || (i_opcode == OP_LDB);
    assign w_is_plain_wr = (i_opcode == OP_STR) || (i_opcode == OP_STB);
    assign w_is_ind      = (i_opcode == OP_LDI) || (i_opcode == OP_STI);
    assign w_accept_ind  = (r_state == S_IDLE) && i_start && w_is_ind;

    // A response landing on the expiry cycle still counts as progress.
    assign w_timeout = TO_EN && (r_state != S_IDLE) && !mem.mem_resp
                       && (r_wait_cnt == TO_LAST);

    always_comb begin
        w_next     = r_state;
        w_read     = 1'b0;
        w_write    = 1'b0;
        w_sel      = 1'b0;
        w_proceed  = 1'b1;
        w_ptr_load = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_is_plain_rd) begin
                        w_read    = 1'b1;
                        w_proceed = mem.mem_resp;
                    end else if (w_is_plain_wr) begin
                        w_write   = 1'b1;
                        w_proceed = mem.mem_resp;
                    end else if (w_is_ind) begin
                        w_read    = 1'b1;
                        w_proceed = 1'b0;
                        w_next    = S_PTR;
                    end
                end
            end
            S_PTR: begin
                w_read    = 1'b1;
                w_sel     = (r_level != 3'd0);
                w_proceed = 1'b0;
                if (w_timeout) begin
                    w_read    = 1'b0;
                    w_proceed = 1'b1;
                    w_next    = S_IDLE;
                end else if (mem.mem_resp) begin
                    w_ptr_load = 1'b1;
                    if (r_level == LAST_LVL)
                        w_next = S_FINAL;
                end
            end
            S_FINAL: begin
                w_sel     = 1'b1;
                w_read    = (r_op_q == OP_LDI);
                w_write   = (r_op_q == OP_STI);
                w_proceed = mem.mem_resp;
                if (w_timeout) begin
                    w_read    = 1'b0;
                    w_write   = 1'b0;
                    w_proceed = 1'b1;
                    w_next    = S_IDLE;
                end else if (mem.mem_resp) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Reset also masks the combinational outputs so strobes drop the instant rst rises.
    assign mem.mem_read    = w_read    && !rst;
    assign mem.mem_write   = w_write   && !rst;
    assign mem.memaddr_sel = w_sel     && !rst;
    assign o_ptr_load      = w_ptr_load && !rst;
    assign o_done          = w_done    && !rst;
    assign o_proceed       = w_proceed || rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr_q       <= '0;
            r_level       <= 3'd0;
            r_op_q        <= 4'd0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept_ind)
                r_op_q <= i_opcode;
            if (w_ptr_load) begin
                r_ptr_q <= mem.mem_rdata;
                r_level <= r_level + 3'd1;
            end
            if (w_done || w_timeout)
                r_level <= 3'd0;
            if ((w_next != r_state) || mem.mem_resp || (r_state == S_IDLE))
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout)
                r_timeout_err <= 1'b1;
            else if (i_err_clear)
                r_timeout_err <= 1'b0;
        end
    end

    assign o_ptr_q       = r_ptr_q;
    assign o_level       = r_level;
    assign o_timeout_err = r_timeout_err;
endmodule

// File: doc/mem_indirect_sequencer.md
Name: mem_indirect_sequencer

Overview:
- Memory-stage controller that sequences every data-memory access of one LC-3b instruction, including multi-level indirection.
- Plain loads/stores (LDR/LDB/STR/STB) take one access.
- LDI/STI take INDIRECT_DEPTH pointer reads followed by one final read or write at the last fetched pointer.
- Drives pipeline stall (proceed), pointer capture, address-mux select and memory strobes; adds a response timeout with a sticky error.

Parameters:
DATA_W, 16, width of mem_rdata and captured pointer
INDIRECT_DEPTH, 1, pointer reads before the final LDI/STI access; legal range 1..4
TIMEOUT_CYCLES, 0, cycles to wait for mem_resp before abort; 0 disables the timeout
CNT_W, 8, width of the wait counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
start  in  1  MEM stage holds a valid instruction this cycle
opcode  in  lc3b_opcode (4)  opcode of the MEM-stage instruction
mem_resp  in  1  memory completed the current access this cycle
mem_rdata  in  DATA_W  read data, valid when mem_resp=1
err_clear  in  1  clears sticky timeout_err
proceed  out  1  1 = MEM stage may advance this cycle
mem_read  out  1  read strobe
mem_write  out  1  write strobe
memaddr_sel  out  1  0 = instruction-computed address, 1 = ptr_q
ptr_load  out  1  one-cycle pulse when ptr_q captures mem_rdata
ptr_q  out  DATA_W  last captured pointer
level  out  3  pointer reads completed in the current sequence
done  out  1  one-cycle pulse when an LDI/STI sequence completes
timeout_err  out  1  sticky, set on any timeout abort

Behaviour:
- Reset (async, any time, including mid-sequence): state=IDLE, ptr_q=0, level=0, op_q=0, wait_cnt=0, timeout_err=0. mem_read, mem_write, memaddr_sel, ptr_load and done are 0 immediately; proceed=1.
- Classification: indirect = op_ldi/op_sti. Plain = op_ldr/op_ldb (read) and op_str/op_stb (write). Every other opcode is non-memory.
- IDLE
  - Non-memory opcode or start=0: proceed=1, no strobes.
  - start with a plain opcode: strobe asserted combinationally, memaddr_sel=0, proceed=mem_resp. Stay in IDLE; no latency beyond memory.
  - start with an indirect opcode: mem_read=1, memaddr_sel=0, proceed=0; op_q<=opcode; go to PTR next cycle. The first pointer read is issued in PTR, not IDLE.
- PTR
  - mem_read=1; memaddr_sel=(level!=0); proceed=0.
  - On mem_resp: ptr_load=1, ptr_q<=mem_rdata, level<=level+1.
  - If level==INDIRECT_DEPTH-1 go to FINAL, else stay in PTR. Strobe continuity: mem_read stays high across back-to-back pointer reads.
- FINAL
  - memaddr_sel=1; mem_read=1 if op_q==op_ldi, mem_write=1 if op_q==op_sti.
  - proceed=mem_resp.
  - On mem_resp: done=1, level<=0, go to IDLE.
- In PTR/FINAL, opcode and start are ignored (op_q governs); mem_resp in IDLE without start is ignored.
- Timeout (TIMEOUT_CYCLES>0 only)
  - wait_cnt clears on state entry and on every mem_resp; otherwise it increments each PTR/FINAL cycle.
  - When wait_cnt==TIMEOUT_CYCLES-1 and mem_resp=0: that cycle strobes drop, proceed=1, timeout_err<=1, level<=0, next state IDLE; ptr_q is retained.
  - mem_resp arriving on the same cycle as expiry wins: normal progress, no error.
- timeout_err: set has priority over err_clear on the same cycle.
- Latency: LDI/STI occupy 1 + (INDIRECT_DEPTH+1)*memory-latency cycles. proceed stays 0 from the IDLE accept until the final mem_resp.

Test Plan:
- Plain path: start, op_ldr, mem_resp after 2 cycles -> mem_read=1 for 3 cycles, proceed 0,0,1, memaddr_sel=0, done=0, state stays IDLE.
- LDI, DEPTH=1: mem_rdata=16'h3000 on first resp -> ptr_q=16'h3000, one ptr_load pulse, FINAL with memaddr_sel=1 and mem_read=1, done and proceed=1 on second resp.
- STI, DEPTH=3: three resps with rdata 16'h1000/16'h2000/16'h3000 -> memaddr_sel 0,1,1 then 1; level 1,2,3; final mem_write=1 at ptr_q=16'h3000; mem_read stays continuous across the pointer reads.
- TIMEOUT_CYCLES=4, no resp in PTR -> abort on the 4th PTR cycle: proceed=1, timeout_err=1 sticky until err_clear; resp on the 4th cycle instead -> no error.
- Async rst asserted mid-FINAL with mem_write=1 -> mem_write=0 and proceed=1 immediately; level=0, ptr_q=0.
- Opcode changed to op_add during PTR -> ignored; sequence completes per op_q.
